// File: rtl/symbol_sprite_drawer_pkg.sv
// Shared definitions for the symbol sprite drawer.
// Holds the screen size, the symbol id encodings, the FSM state encoding
// and the symbol colour lookup.
package symbol_sprite_drawer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    SYM_SQUARE = 2'd0,
    SYM_CROSS  = 2'd1,
    SYM_BORDER = 2'd2,
    SYM_PLUS   = 2'd3
  } sym_id_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Foreground colour for each symbol.
  function automatic logic [2:0] sym_colour(input logic [1:0] id);
    logic [2:0] c;
    case (sym_id_e'(id))
      SYM_SQUARE: c = 3'b100;
      SYM_CROSS:  c = 3'b010;
      SYM_BORDER: c = 3'b001;
      SYM_PLUS:   c = 3'b110;
      default:    c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/symbol_rom.sv
// Combinational symbol pattern lookup.
// Ports: i_sym_id (symbol select), i_row / i_col (pixel within the symbol),
//        o_bit (1 = foreground pixel).
// Patterns: id0 filled square, id1 diagonal cross, id2 hollow border,
//           id3 plus sign through row SYM_H/2 and column SYM_W/2.
module symbol_rom
  import symbol_sprite_drawer_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int SYM_H = 8,
  parameter int RW    = 3,
  parameter int CW    = 3
) (
  input  logic [1:0]    i_sym_id,
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  output logic          o_bit
);

  logic [15:0] w_r;
  logic [15:0] w_c;

  assign w_r = 16'(i_row);
  assign w_c = 16'(i_col);

  // Pattern bit for the selected symbol at (row, col).
  always_comb begin
    o_bit = 1'b0;
    case (sym_id_e'(i_sym_id))
      SYM_SQUARE: o_bit = 1'b1;
      SYM_CROSS:  o_bit = (w_r == w_c) || ((w_r + w_c) == 16'(SYM_W - 1));
      SYM_BORDER: o_bit = (w_r == 16'd0) || (w_r == 16'(SYM_H - 1)) ||
                          (w_c == 16'd0) || (w_c == 16'(SYM_W - 1));
      SYM_PLUS:   o_bit = (w_r == 16'(SYM_H / 2)) || (w_c == 16'(SYM_W / 2));
      default:    o_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/symbol_sprite_drawer.sv
// Draws one SYM_W x SYM_H symbol at a screen origin, one pixel per clock.
// Ports: clk, reset_n (async active-low); start/x_org/y_org/sym_id/transparent
//        request a draw (sampled in IDLE only); x/y/colour/plot present one
//        registered pixel per cycle; busy is high while pixels are presented,
//        done pulses for one cycle after the last pixel.
// Pixel 0 is computed straight from the request inputs on the accepting edge
// so it appears one cycle after acceptance; later pixels use the latched copy.
module symbol_sprite_drawer
  import symbol_sprite_drawer_pkg::*;
#(
  parameter int         SYM_W     = 8,
  parameter int         SYM_H     = 8,
  parameter logic [2:0] BG_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_org,
  input  logic [6:0] y_org,
  input  logic [1:0] sym_id,
  input  logic       transparent,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int RW = (SYM_H > 1) ? $clog2(SYM_H) : 1;
  localparam int CW = (SYM_W > 1) ? $clog2(SYM_W) : 1;

  state_e        r_state;
  logic [7:0]    r_x_org;
  logic [6:0]    r_y_org;
  logic [1:0]    r_sym_id;
  logic          r_transp;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_last;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;
  logic          r_busy;
  logic          r_done;

  logic [7:0]    w_src_x;
  logic [6:0]    w_src_y;
  logic [1:0]    w_src_id;
  logic          w_src_transp;
  logic [RW-1:0] w_src_row;
  logic [CW-1:0] w_src_col;
  logic [8:0]    w_px;
  logic [7:0]    w_py;
  logic          w_clip;
  logic          w_bit;
  logic          w_pix_plot;
  logic [2:0]    w_pix_colour;
  logic          w_col_last;
  logic          w_row_last;
  logic [RW-1:0] w_next_row;
  logic [CW-1:0] w_next_col;

  // In IDLE the pixel source is the live request (pixel 0); while drawing it is the latched request.
  always_comb begin
    if (r_state == ST_DRAW) begin
      w_src_x      = r_x_org;
      w_src_y      = r_y_org;
      w_src_id     = r_sym_id;
      w_src_transp = r_transp;
      w_src_row    = r_row;
      w_src_col    = r_col;
    end else begin
      w_src_x      = x_org;
      w_src_y      = y_org;
      w_src_id     = sym_id;
      w_src_transp = transparent;
      w_src_row    = {RW{1'b0}};
      w_src_col    = {CW{1'b0}};
    end
  end

  symbol_rom #(
    .SYM_W (SYM_W),
    .SYM_H (SYM_H),
    .RW    (RW),
    .CW    (CW)
  ) u_rom (
    .i_sym_id (w_src_id),
    .i_row    (w_src_row),
    .i_col    (w_src_col),
    .o_bit    (w_bit)
  );

  // Coordinates are widened by one bit so an off-screen sum cannot wrap back on screen.
  assign w_px   = {1'b0, w_src_x} + 9'(w_src_col);
  assign w_py   = {1'b0, w_src_y} + 8'(w_src_row);
  assign w_clip = w_px[8] || (w_px[7:0] > 8'(SCREEN_W - 1)) ||
                  w_py[7] || (w_py[6:0] > 7'(SCREEN_H - 1));

  assign w_pix_plot   = !w_clip && (w_bit || !w_src_transp);
  assign w_pix_colour = w_bit ? sym_colour(w_src_id) : BG_COLOUR;

  assign w_col_last = (w_src_col == CW'(SYM_W - 1));
  assign w_row_last = (w_src_row == RW'(SYM_H - 1));

  // Row-major scan with column fastest.
  always_comb begin
    if (w_col_last) begin
      w_next_col = {CW{1'b0}};
      w_next_row = w_row_last ? {RW{1'b0}} : (w_src_row + RW'(1));
    end else begin
      w_next_col = w_src_col + CW'(1);
      w_next_row = w_src_row;
    end
  end

  // Draw FSM with counters and registered pixel outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_x_org  <= 8'd0;
      r_y_org  <= 7'd0;
      r_sym_id <= 2'd0;
      r_transp <= 1'b0;
      r_row    <= {RW{1'b0}};
      r_col    <= {CW{1'b0}};
      r_last   <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_plot <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_x_org  <= x_org;
            r_y_org  <= y_org;
            r_sym_id <= sym_id;
            r_transp <= transparent;
            r_x      <= w_px[7:0];
            r_y      <= w_py[6:0];
            r_colour <= w_pix_colour;
            r_plot   <= w_pix_plot;
            r_row    <= w_next_row;
            r_col    <= w_next_col;
            r_last   <= w_col_last && w_row_last;
            r_busy   <= 1'b1;
            r_state  <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          // r_last marks that the final pixel is already on the outputs.
          if (r_last) begin
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_row   <= {RW{1'b0}};
            r_col   <= {CW{1'b0}};
            r_last  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_x      <= w_px[7:0];
            r_y      <= w_py[6:0];
            r_colour <= w_pix_colour;
            r_plot   <= w_pix_plot;
            r_row    <= w_next_row;
            r_col    <= w_next_col;
            r_last   <= w_col_last && w_row_last;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_plot  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_symbol_sprite_drawer.sv
// Scoreboard bench for symbol_sprite_drawer: stimulus pushes expected pixels
// and done cycles into queues, a negedge monitor pops and compares them.
module tb_symbol_sprite_drawer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] x_org;
  logic [6:0] y_org;
  logic [1:0] sym_id;
  logic       transparent;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  symbol_sprite_drawer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .x_org       (x_org),
    .y_org       (y_org),
    .sym_id      (sym_id),
    .transparent (transparent),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int cyc;
    int px;
    int py;
    int col;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_plots = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit pat(input int id, input int r, input int c);
    case (id)
      0:       return 1'b1;
      1:       return (r == c) || (r + c == 7);
      2:       return (r == 0) || (r == 7) || (c == 0) || (c == 7);
      3:       return (r == 4) || (c == 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int fg(input int id);
    case (id)
      0:       return 4;
      1:       return 2;
      2:       return 1;
      3:       return 6;
      default: return 0;
    endcase
  endfunction

  // Push expected pixels k < kmax of a draw accepted in cycle t.
  task automatic push_exp(input int xo, input int yo, input int id, input bit tr,
                          input int kmax, input bit with_done, input int t);
    pix_t e;
    bit   b;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        if ((r * 8 + c) < kmax && (xo + c) <= 159 && (yo + r) <= 119) begin
          b = pat(id, r, c);
          if (b || !tr) begin
            e.cyc = t + 1 + r * 8 + c;
            e.px  = xo + c;
            e.py  = yo + r;
            e.col = b ? fg(id) : 7;
            exp_q.push_back(e);
          end
        end
      end
    end
    if (with_done) done_q.push_back(t + 65);
  endtask

  // Called at negedge+1; issues a one-cycle start and returns the accept cycle.
  task automatic start_draw(input int xo, input int yo, input int id, input bit tr,
                            input int kmax, input bit with_done, output int t);
    x_org       = 8'(xo);
    y_org       = 7'(yo);
    sym_id      = 2'(id);
    transparent = tr;
    start       = 1'b1;
    t           = cyc;
    push_exp(xo, yo, id, tr, kmax, with_done, t);
    @(negedge clk); #1;
    start       = 1'b0;
    x_org       = 8'hAA;
    y_org       = 7'h55;
    sym_id      = ~sym_id;
    transparent = ~transparent;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      chk("draw_timeout", exp_q.size() + done_q.size(), 0);
      exp_q.delete();
      done_q.delete();
    end
    @(negedge clk); #1;
  endtask

  // Monitor: compare every presented pixel and done pulse against the queues.
  always @(negedge clk) begin
    pix_t e;
    int   d;
    if (reset_n) begin
      if (plot) begin
        n_plots++;
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_cycle", cyc, e.cyc);
          chk("pix_x", int'(x), e.px);
          chk("pix_y", int'(y), e.py);
          chk("pix_colour", int'(colour), e.col);
          chk("busy_while_plot", int'(busy), 1);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d);
          chk("busy_at_done", int'(busy), 0);
          chk("plot_at_done", int'(plot), 0);
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    reset_n     = 1'b0;
    start       = 1'b0;
    x_org       = 8'd0;
    y_org       = 7'd0;
    sym_id      = 2'd0;
    transparent = 1'b0;
    #1;
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk); #1;

    // Filled square, opaque, fully on screen.
    n_plots = 0;
    start_draw(50, 30, 0, 1'b0, 64, 1'b1, t0);
    chk("busy_after_start", int'(busy), 1);
    wait_done();
    chk("plots_square", n_plots, 64);

    // Hollow border, transparent: border pixels only.
    n_plots = 0;
    start_draw(10, 5, 2, 1'b1, 64, 1'b1, t0);
    wait_done();
    chk("plots_border_transp", n_plots, 28);

    // Clipped at the bottom-right corner.
    n_plots = 0;
    start_draw(155, 115, 0, 1'b0, 64, 1'b1, t0);
    wait_done();
    chk("plots_clipped", n_plots, 25);

    // Diagonal cross, opaque: mixes foreground and background.
    n_plots = 0;
    start_draw(0, 0, 1, 1'b0, 64, 1'b1, t0);
    wait_done();
    chk("plots_cross_opaque", n_plots, 64);

    // Plus sign, transparent.
    n_plots = 0;
    start_draw(100, 60, 3, 1'b1, 64, 1'b1, t0);
    wait_done();
    chk("plots_plus_transp", n_plots, 15);

    // Starts in DRAW and DONE are ignored; the next IDLE cycle accepts.
    n_plots = 0;
    start_draw(20, 20, 0, 1'b0, 64, 1'b1, t0);
    to_cycle(t0 + 10);
    x_org = 8'd0; y_org = 7'd0; sym_id = 2'd2; transparent = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    to_cycle(t0 + 65);
    chk("done_before_restart", int'(done), 1);
    x_org = 8'd10; y_org = 7'd10; sym_id = 2'd3; transparent = 1'b0;
    start = 1'b1;
    t1 = t0 + 66;
    push_exp(10, 10, 3, 1'b0, 64, 1'b1, t1);
    @(negedge clk); #1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    chk("plots_back_to_back", n_plots, 128);

    // Reset in the middle of a draw aborts it.
    n_plots = 0;
    start_draw(50, 30, 0, 1'b0, 20, 1'b0, t0);
    to_cycle(t0 + 20);
    chk("busy_before_abort", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_x", int'(x), 0);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (70) @(negedge clk);
    #1;
    chk("plots_before_abort", n_plots, 20);
    chk("abort_leftover", exp_q.size() + done_q.size(), 0);

    // Restart after abort begins at the origin.
    n_plots = 0;
    start_draw(50, 30, 0, 1'b0, 64, 1'b1, t0);
    wait_done();
    chk("plots_after_abort", n_plots, 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_sprite_drawer.md
SYMBOL_SPRITE_DRAWER -- requirements
Module: symbol_sprite_drawer

Interface
REQ-001 Parameter SYM_W, default 8: symbol width in pixels.
REQ-002 Parameter SYM_H, default 8: symbol height in pixels.
REQ-003 Parameter BG_COLOUR, default 3'b111: card background colour for non-transparent draws.
REQ-004 clk  input  1  system clock, all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle draw request; sampled only in IDLE.
REQ-007 x_org  input  8  symbol top-left x, latched on accepted start.
REQ-008 y_org  input  7  symbol top-left y, latched on accepted start.
REQ-009 sym_id  input  2  symbol select, latched on accepted start.
REQ-010 transparent  input  1  1 = background pixels suppressed, latched on accepted start.
REQ-011 x  output  8  pixel x to VGA adapter.
REQ-012 y  output  7  pixel y to VGA adapter.
REQ-013 colour  output  3  pixel colour.
REQ-014 plot  output  1  write enable for the presented pixel.
REQ-015 busy  output  1  high while drawing.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, DRAW, DONE; IDLE->DRAW on start; DRAW->DONE after last pixel; DONE->IDLE unconditionally.
REQ-018 Start accepted in cycle T (IDLE, start=1): origin, sym_id, transparent latched at T.
REQ-019 Pixel k (k = 0..SYM_W*SYM_H-1, row-major, col fastest) presented on registered outputs at cycle T+1+k.
REQ-020 Pixel (row,col) coordinates: x = x_org+col, y = y_org+row.
REQ-021 Pattern bit 1 -> plot=1, colour = symbol colour: id0 3'b100, id1 3'b010, id2 3'b001, id3 3'b110.
REQ-022 Pattern bit 0 -> transparent=0: plot=1, colour=BG_COLOUR; transparent=1: plot=0.
REQ-023 Clipping: x_org+col > 159 or y_org+row > 119 -> plot=0 for that pixel; sums computed at 9/8 bits, no wrap.
REQ-024 busy=1 from T+1 through T+SYM_W*SYM_H; done=1 for exactly cycle T+SYM_W*SYM_H+1 (DONE state), busy=0 then.
REQ-025 start ignored in DRAW and DONE; earliest next accept is IDLE cycle T+SYM_W*SYM_H+2.
REQ-026 plot=0 in IDLE and DONE; x, y, colour hold last values there.
REQ-027 Input changes after acceptance do not affect an in-progress draw.

Reset
REQ-028 reset_n low -> state IDLE, counters 0, x=0, y=0, colour=0, plot=0, busy=0, done=0, immediately.
REQ-029 Reset mid-DRAW aborts: no further plot, no done pulse; next start after release begins at pixel 0.

Structure
REQ-030 Shared package holds SCREEN_W=160, SCREEN_H=120, symbol id encodings, symbol colour table.
REQ-031 Sub-module symbol_rom: combinational lookup (sym_id, row, col) -> pattern bit; patterns: id0 filled square, id1 diagonal cross, id2 hollow border, id3 plus sign.
REQ-032 Row/col counters and output registers in top; single pipeline register stage only.

Verification
REQ-033 Reset, start at T with x_org=50, y_org=30, sym_id=0, transparent=0 -> 64 plots, x 50..57, y 30..37, all colour 3'b100, done at T+65.
REQ-034 sym_id=2, transparent=1 -> plot=1 only on 28 border pixels, colour 3'b001; interior plot=0.
REQ-035 x_org=155, y_org=115, sym_id=0 -> only 25 pixels (x 155..159, y 115..119) plotted, done still at T+65.
REQ-036 start pulsed at T+10 and T+65 -> both ignored; start at T+66 accepted, first pixel at T+67.
REQ-037 reset_n low at T+20 -> plot, busy, done 0 immediately; no done pulse; restart draws from (x_org,y_org).
